// File: rtl/vga_scanout_if.sv
// Frame-buffer read port between the VGA scan-out engine and video memory.
//
// Signals:
//   rd_addr  frame-buffer read address (nA bits), driven by the scan-out side
//   rd_en    one-CLOCK_50-cycle read strobe, driven by the scan-out side
//   rd_data  9-bit colour {R[2:0], G[2:0], B[2:0]} returned by memory one
//            cycle after rd_en/rd_addr are sampled
//
// Modports:
//   master   scan-out engine (issues reads, consumes data)
//   slave    video memory (serves reads)
interface vga_scanout_if #(
  parameter int nA = 17
) ();
  logic [nA-1:0] rd_addr;
  logic          rd_en;
  logic [8:0]    rd_data;

  modport master (
    output rd_addr,
    output rd_en,
    input  rd_data
  );

  modport slave (
    input  rd_addr,
    input  rd_en,
    output rd_data
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA scan-out engine: reads the pixel frame buffer in raster order and drives
// the DE1-SoC VGA DAC with 640x480 @ 60 Hz timing derived from CLOCK_50.
//
// A divide-by-2 phase register produces the 25 MHz pixel tick. Each tick the
// (h, v) raster counters advance; for visible pixels a one-cycle read is issued
// to the frame buffer. Syncs and blank are pipelined through one stage so that
// they reach the DAC on the same tick as the colour read for that pixel.
// Downscaled buffers are supported by replicating each buffer pixel/line
// 2^SHIFT times; the buffer row base is stepped by addition, not multiplied.
//
// Ports:
//   CLOCK_50     system clock, 50 MHz
//   Resetn       synchronous, active-low reset
//   fb           frame-buffer read port (master side): rd_addr, rd_en, rd_data
//   VGA_R/G/B    8-bit DAC colour, zero outside the visible area
//   VGA_HS       horizontal sync, active low
//   VGA_VS       vertical sync, active low
//   VGA_BLANK_N  high during visible pixels
//   VGA_SYNC_N   tied low (sync-on-green unused)
//   VGA_CLK      25 MHz pixel clock
//   frame_start  one-cycle pulse after the tick at pixel (0,0)
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SHIFT    = 1,
  parameter int nA       = 17
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  vga_scanout_if.master fb,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Low SHIFT bits of (v+1) are zero when the last replica of a buffer row
  // has just been displayed; with SHIFT=0 the mask is empty and every line
  // advances the row base.
  localparam logic [VW-1:0] ROW_MASK = VW'((1 << SHIFT) - 1);
  localparam logic [nA-1:0] ROW_STEP = nA'(H_ACTIVE >> SHIFT);

  // Expand a 3-bit channel to 8 bits by bit replication so that full scale
  // maps to 0xFF and zero maps to 0x00.
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  // Pixel phase and raster state
  logic          phase_r;
  logic [HW-1:0] h_r;
  logic [VW-1:0] v_r;
  logic [nA-1:0] row_base_r;

  // Read port registers
  logic          rd_en_r;
  logic [nA-1:0] rd_addr_r;

  // Stage-1 pipeline: timing flags for the pixel whose read is in flight
  logic          active_p_r;
  logic          hs_n_p_r;
  logic          vs_n_p_r;

  // Combinational next-state terms
  logic          tick_s;
  logic          h_last_s;
  logic          v_last_s;
  logic          active_s;
  logic          hs_n_s;
  logic          vs_n_s;
  logic          row_done_s;
  logic [HW-1:0] h_next_s;
  logic [VW-1:0] v_next_s;
  logic [nA-1:0] row_base_next_s;
  logic [nA-1:0] rd_addr_next_s;

  assign VGA_CLK    = phase_r;
  assign VGA_SYNC_N = 1'b0;
  assign fb.rd_en   = rd_en_r;
  assign fb.rd_addr = rd_addr_r;

  // Raster decode: region flags, sync windows and counter/row-base next values
  always_comb begin
    tick_s          = phase_r;
    h_last_s        = (h_r == H_LAST);
    v_last_s        = (v_r == V_LAST);
    active_s        = (h_r < H_ACT) && (v_r < V_ACT);
    hs_n_s          = !((h_r >= HS_BEGIN) && (h_r < HS_END));
    vs_n_s          = !((v_r >= VS_BEGIN) && (v_r < VS_END));
    row_done_s      = (((v_r + VW'(1)) & ROW_MASK) == VW'(0));
    h_next_s        = h_r;
    v_next_s        = v_r;
    row_base_next_s = row_base_r;
    rd_addr_next_s  = row_base_r + nA'(h_r >> SHIFT);

    if (h_last_s) begin
      h_next_s = HW'(0);
    end else begin
      h_next_s = h_r + HW'(1);
    end

    if (!h_last_s) begin
      v_next_s        = v_r;
      row_base_next_s = row_base_r;
    end else if (v_last_s) begin
      v_next_s        = VW'(0);
      row_base_next_s = nA'(0);
    end else if ((v_r < V_ACT) && row_done_s) begin
      v_next_s        = v_r + VW'(1);
      row_base_next_s = row_base_r + ROW_STEP;
    end else begin
      v_next_s        = v_r + VW'(1);
      row_base_next_s = row_base_r;
    end
  end

  // Divide-by-2 pixel phase; the edge where phase is 1 is the pixel tick
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      phase_r <= 1'b0;
    end else begin
      phase_r <= ~phase_r;
    end
  end

  // Raster counters and buffer row base, advanced once per pixel tick
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      h_r        <= HW'(0);
      v_r        <= VW'(0);
      row_base_r <= nA'(0);
    end else if (tick_s) begin
      h_r        <= h_next_s;
      v_r        <= v_next_s;
      row_base_r <= row_base_next_s;
    end else begin
      h_r        <= h_r;
      v_r        <= v_r;
      row_base_r <= row_base_r;
    end
  end

  // Read issue and frame pulse: set on a tick, cleared on the following edge
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      rd_en_r     <= 1'b0;
      rd_addr_r   <= nA'(0);
      frame_start <= 1'b0;
    end else if (tick_s) begin
      frame_start <= (h_r == HW'(0)) && (v_r == VW'(0));
      if (active_s) begin
        rd_en_r   <= 1'b1;
        rd_addr_r <= rd_addr_next_s;
      end else begin
        rd_en_r   <= 1'b0;
        rd_addr_r <= rd_addr_r;
      end
    end else begin
      rd_en_r     <= 1'b0;
      rd_addr_r   <= rd_addr_r;
      frame_start <= 1'b0;
    end
  end

  // Stage 1: hold the timing flags while the memory read is outstanding
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      active_p_r <= 1'b0;
      hs_n_p_r   <= 1'b1;
      vs_n_p_r   <= 1'b1;
    end else if (tick_s) begin
      active_p_r <= active_s;
      hs_n_p_r   <= hs_n_s;
      vs_n_p_r   <= vs_n_s;
    end else begin
      active_p_r <= active_p_r;
      hs_n_p_r   <= hs_n_p_r;
      vs_n_p_r   <= vs_n_p_r;
    end
  end

  // Stage 2: DAC outputs; read data is used only for visible pixels
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (tick_s) begin
      VGA_HS      <= hs_n_p_r;
      VGA_VS      <= vs_n_p_r;
      VGA_BLANK_N <= active_p_r;
      if (active_p_r) begin
        VGA_R <= expand3(fb.rd_data[8:6]);
        VGA_G <= expand3(fb.rd_data[5:3]);
        VGA_B <= expand3(fb.rd_data[2:0]);
      end else begin
        VGA_R <= 8'h00;
        VGA_G <= 8'h00;
        VGA_B <= 8'h00;
      end
    end else begin
      VGA_R       <= VGA_R;
      VGA_G       <= VGA_G;
      VGA_B       <= VGA_B;
      VGA_HS      <= VGA_HS;
      VGA_VS      <= VGA_VS;
      VGA_BLANK_N <= VGA_BLANK_N;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed testbench for vga_scanout.
// Horizontal timing uses the real 640-pixel line; the vertical geometry is
// shortened (8 active lines, 15 lines per frame) so two full frames fit in a
// short run. Frame = 15 * 800 ticks = 24000 CLOCK_50 cycles.
// edge_n counts posedges since the last reset release, so the tick for
// pixel (h,v) is edge 2 + 2*(800*v + h) and its DAC output appears two
// edges later.
module tb_vga_scanout;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start;

  vga_scanout_if #(.nA(17)) fb ();

  vga_scanout #(
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SHIFT(1), .nA(17)
  ) dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .fb(fb),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK), .frame_start(frame_start)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Memory contents: odd addresses hold 101_010_111, even ones 000_111_001
  function automatic logic [8:0] mem_val(input logic [16:0] a);
    return a[0] ? 9'b101_010_111 : 9'b000_111_001;
  endfunction

  // Synchronous-read frame buffer model
  always @(posedge CLOCK_50) begin
    if (fb.rd_en) fb.rd_data <= mem_val(fb.rd_addr);
  end

  // Posedge counter since reset release
  int edge_n = 0;
  always @(posedge CLOCK_50) begin
    if (!Resetn) edge_n <= 0;
    else         edge_n <= edge_n + 1;
  end

  // Monitor state
  int          pass_id      = 0;
  logic        prev_hs      = 1'b1;
  logic        prev_vs      = 1'b1;
  logic        prev_rd      = 1'b0;
  int          hs_fall[4];
  int          hs_fall_n    = 0;
  int          hs_width     = 0;
  int          vs_fall      = -1;
  int          vs_width     = 0;
  int          blank_cnt    = 0;
  int          fs_at[4];
  int          fs_n         = 0;
  int          rd_cnt       = 0;
  int          rd_idx       = 0;
  int          rd_bad_line  = 0;
  int          rd_double    = 0;
  logic [16:0] addr_log[5120];
  logic [23:0] px0_rgb, px2_rgb, blk_rgb;
  logic        px2_blank, blk_blank;

  // Negedge sampler for the two-frame timing run
  always @(negedge CLOCK_50) begin
    if (pass_id == 1) begin
      if (prev_hs && !VGA_HS) begin
        if (hs_fall_n < 4) hs_fall[hs_fall_n] <= edge_n;
        hs_fall_n <= hs_fall_n + 1;
      end
      if (!prev_hs && VGA_HS && hs_fall_n > 0 && hs_width == 0) hs_width <= edge_n - hs_fall[0];
      if (prev_vs && !VGA_VS && vs_fall < 0) vs_fall <= edge_n;
      if (!prev_vs && VGA_VS && vs_fall >= 0 && vs_width == 0) vs_width <= edge_n - vs_fall;
      if (edge_n <= 1600 && VGA_BLANK_N) blank_cnt <= blank_cnt + 1;
      if (frame_start) begin
        if (fs_n < 4) fs_at[fs_n] <= edge_n;
        fs_n <= fs_n + 1;
      end
      if (fb.rd_en) begin
        if (edge_n < 48000) rd_cnt <= rd_cnt + 1;
        if ((((edge_n - 2) / 1600) % 15) >= 8) rd_bad_line <= rd_bad_line + 1;
        if (prev_rd) rd_double <= rd_double + 1;
        if (rd_idx < 5120) addr_log[rd_idx] <= fb.rd_addr;
        rd_idx <= rd_idx + 1;
      end
      if (edge_n == 4) px0_rgb <= {VGA_R, VGA_G, VGA_B};
      if (edge_n == 8) begin
        px2_rgb   <= {VGA_R, VGA_G, VGA_B};
        px2_blank <= VGA_BLANK_N;
      end
      if (edge_n == 1404) begin
        blk_rgb   <= {VGA_R, VGA_G, VGA_B};
        blk_blank <= VGA_BLANK_N;
      end
    end
    prev_hs <= VGA_HS;
    prev_vs <= VGA_VS;
    prev_rd <= fb.rd_en;
  end

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_r"},       32'(VGA_R), 32'h00);
    check_val({pfx, "_g"},       32'(VGA_G), 32'h00);
    check_val({pfx, "_b"},       32'(VGA_B), 32'h00);
    check_val({pfx, "_hs"},      32'(VGA_HS), 32'd1);
    check_val({pfx, "_vs"},      32'(VGA_VS), 32'd1);
    check_val({pfx, "_blank_n"}, 32'(VGA_BLANK_N), 32'd0);
    check_val({pfx, "_rd_en"},   32'(fb.rd_en), 32'd0);
    check_val({pfx, "_vga_clk"}, 32'(VGA_CLK), 32'd0);
    check_val({pfx, "_sync_n"},  32'(VGA_SYNC_N), 32'd0);
    check_val({pfx, "_fs"},      32'(frame_start), 32'd0);
  endtask

  initial begin
    int line_bad;

    // Power-up reset, run into the middle of line 0, then reset for 5 cycles
    repeat (3) @(negedge CLOCK_50);
    Resetn = 1'b1;
    repeat (300) @(negedge CLOCK_50);
    check_val("pre_reset_blank_n", 32'(VGA_BLANK_N), 32'd1);
    Resetn = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check_reset_outputs("rst");

    // Release and start the two-frame run; VGA_CLK toggles every cycle
    pass_id = 1;
    Resetn  = 1'b1;
    @(negedge CLOCK_50); check_val("vga_clk_e1", 32'(VGA_CLK), 32'd1);
    @(negedge CLOCK_50); check_val("vga_clk_e2", 32'(VGA_CLK), 32'd0);
    @(negedge CLOCK_50); check_val("vga_clk_e3", 32'(VGA_CLK), 32'd1);
    repeat (48100 - 3) @(negedge CLOCK_50);

    // Line timing: tick h=656 at edge 1314 -> HS low from edge 1316
    check_val("hs_first_fall", 32'(hs_fall[0]), 32'd1316);
    check_val("hs_low_width", 32'(hs_width), 32'd192);
    check_val("hs_period", 32'(hs_fall[1] - hs_fall[0]), 32'd1600);
    check_val("blank_high_line0", 32'(blank_cnt), 32'd1280);

    // Frame timing: tick (0,10) at edge 16002 -> VS low from 16004 for 2 lines
    check_val("vs_first_fall", 32'(vs_fall), 32'd16004);
    check_val("vs_low_width", 32'(vs_width), 32'd3200);
    check_val("fs_first", 32'(fs_at[0]), 32'd2);
    check_val("fs_period", 32'(fs_at[1] - fs_at[0]), 32'd24000);
    check_val("fs_count", 32'(fs_n), 32'd3);
    check_val("rd_count_2frames", 32'(rd_cnt), 32'd10240);
    check_val("rd_in_vblank", 32'(rd_bad_line), 32'd0);
    check_val("rd_en_multi_cycle", 32'(rd_double), 32'd0);

    // Addressing with 2x replication: 320-entry buffer rows
    check_val("addr_0", 32'(addr_log[0]), 32'd0);
    check_val("addr_1", 32'(addr_log[1]), 32'd0);
    check_val("addr_2", 32'(addr_log[2]), 32'd1);
    check_val("addr_639", 32'(addr_log[639]), 32'd319);
    check_val("addr_line2_start", 32'(addr_log[1280]), 32'd320);
    check_val("addr_h3_v5", 32'(addr_log[3203]), 32'd641);
    check_val("addr_last", 32'(addr_log[5119]), 32'd1279);
    line_bad = 0;
    for (int k = 0; k < 1280; k++) begin
      if (addr_log[k] !== 17'((k % 640) / 2)) line_bad++;
    end
    check_val("addr_lines01_pattern", 32'(line_bad), 32'd0);

    // Colour expansion and blanking
    check_val("px0_rgb", 32'(px0_rgb), 32'h00FF24);
    check_val("px2_rgb", 32'(px2_rgb), 32'hB649FF);
    check_val("px2_blank_n", 32'(px2_blank), 32'd1);
    check_val("blank_rgb", 32'(blk_rgb), 32'h000000);
    check_val("blank_blank_n", 32'(blk_blank), 32'd0);

    // Mid-frame reset at pixel (100,5) of the third frame
    repeat (56202 - 48100) @(negedge CLOCK_50);
    pass_id = 2;
    check_val("midframe_blank_n", 32'(VGA_BLANK_N), 32'd1);
    check_val("midframe_rd_en", 32'(fb.rd_en), 32'd1);
    Resetn = 1'b0;
    @(negedge CLOCK_50);
    check_reset_outputs("mrst");
    Resetn = 1'b1;
    @(negedge CLOCK_50);
    check_val("mrst_e1_clk", 32'(VGA_CLK), 32'd1);
    check_val("mrst_e1_fs", 32'(frame_start), 32'd0);
    check_val("mrst_e1_rd_en", 32'(fb.rd_en), 32'd0);
    @(negedge CLOCK_50);
    check_val("mrst_e2_fs", 32'(frame_start), 32'd1);
    check_val("mrst_e2_rd_en", 32'(fb.rd_en), 32'd1);
    check_val("mrst_e2_addr", 32'(fb.rd_addr), 32'd0);
    @(negedge CLOCK_50);
    check_val("mrst_e3_fs", 32'(frame_start), 32'd0);
    check_val("mrst_e3_rd_en", 32'(fb.rd_en), 32'd0);
    @(negedge CLOCK_50);
    check_val("mrst_e4_addr", 32'(fb.rd_addr), 32'd0);
    check_val("mrst_e4_blank_n", 32'(VGA_BLANK_N), 32'd1);
    repeat (2) @(negedge CLOCK_50);
    check_val("mrst_e6_addr", 32'(fb.rd_addr), 32'd1);
    check_val("mrst_e6_hs", 32'(VGA_HS), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Reader side of the pixel frame buffer. The drawing logic writes (x, y, color) into video memory; this block reads that memory back in raster order and drives the DE1-SoC VGA DAC.
- Generates 640x480 @ 60 Hz timing from CLOCK_50 using a divide-by-2 pixel tick.
- Issues synchronous memory reads and expands 9-bit color to 24-bit RGB.
- Supports downscaled buffers by pixel/line replication (SHIFT).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SHIFT, 1, buffer downscale (0..2); buffer is (H_ACTIVE>>SHIFT) x (V_ACTIVE>>SHIFT)
nA, 17, read address width, must be >= ceil(log2 of buffer size)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
Resetn  in  1  synchronous, active-low reset
rd_addr  out  nA  frame buffer read address, registered
rd_en  out  1  one-CLOCK_50-cycle read strobe, registered
rd_data  in  9  memory data, valid 1 cycle after rd_en/rd_addr are sampled; [8:6]=R, [5:3]=G, [2:0]=B
VGA_R / VGA_G / VGA_B  out  8 each  DAC color
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK_N  out  1  high during visible pixels
VGA_SYNC_N  out  1  constant 0
VGA_CLK  out  1  pixel clock, 25 MHz
frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset is synchronous, active-low, sampled on posedge CLOCK_50. Reset values:
  - phase=0, h=0, v=0, src_row_base=0.
  - rd_en=0, rd_addr=0.
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
  - frame_start=0, VGA_CLK=0.
- Pixel tick and VGA_CLK:
  - phase toggles every non-reset edge; VGA_CLK = phase.
  - tick = (phase==1). All counter and pipeline updates occur only on tick edges, except that frame_start and rd_en clear on the next edge.
- Counters:
  - h runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - v runs 0..V_TOTAL-1, where V_TOTAL = 525.
  - h wraps to 0 and v increments on the tick where h==H_TOTAL-1.
  - v wraps to 0 on the tick where v==V_TOTAL-1 and h==H_TOTAL-1.
- Active region: h<H_ACTIVE and v<V_ACTIVE.
- Read issue: on a tick edge with (h,v) active:
  - rd_en<=1 and rd_addr <= src_row_base + (h>>SHIFT).
  - rd_en is high for exactly one CLOCK_50 cycle.
  - Outside the active region rd_en stays 0 and rd_addr holds its value.
- Row base: no multiplier is used; src_row_base is updated at line wrap:
  - v wraps to 0: src_row_base <= 0.
  - v < V_ACTIVE and ((v+1) mod 2^SHIFT)==0: src_row_base += H_ACTIVE>>SHIFT.
  - Otherwise src_row_base holds.
- Pipeline stage 1 (tick edge T): register active, hs_n and vs_n for the current (h,v).
  - hs_n=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_n=0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
- Pipeline stage 2 (next tick edge T+2): VGA outputs for pixel (h,v) update.
  - VGA_HS and VGA_VS take the stage-1 values.
  - VGA_BLANK_N takes the stage-1 active flag.
  - RGB = expand(rd_data) if active, else 0.
  - Latency is therefore one pixel tick (2 CLOCK_50 cycles) from the rd_addr issue. Syncs and blank are delayed identically, so alignment is exact.
- Color expansion: each 3-bit channel c maps to 8 bits as {c, c, c[2:1]}. Examples: 000->00, 111->FF, 101->B6.
- frame_start: high for the single CLOCK_50 cycle following a tick edge at which h==0 and v==0. The first pulse therefore follows the first tick after reset release.
- Boundaries:
  - The last active read per frame is address (H_ACTIVE>>SHIFT)*(V_ACTIVE>>SHIFT)-1, which is 76799 at defaults.
  - Reset asserted mid-frame takes effect on the next edge; no partial line is completed.
  - rd_data is ignored when the pipelined active flag is 0.

Test Plan:
1. Reset: hold Resetn=0 for 5 cycles mid-line -> RGB=0, HS=VS=1, BLANK_N=0, rd_en=0, VGA_CLK=0, SYNC_N=0; after release VGA_CLK toggles every cycle.
2. Line timing: run one line -> HS low for exactly 192 CLOCK_50 cycles (96 ticks), starting 2 cycles after the tick with h=656; HS falling-edge period is 1600 cycles; BLANK_N high for 1280 cycles per visible line.
3. Frame timing: run 2 frames -> VS low for 3200 cycles starting at line 490; frame_start period 840000 cycles; no rd_en during lines 480..524.
4. Addressing at SHIFT=1: log rd_addr -> line 0 reads 0,0,1,1,...,319,319; line 1 repeats line 0; line 2 starts at 320; pixel (h=3,v=5) reads 641; the last read of the frame is 76799.
5. Color: memory returns 9'b101_010_111 -> one tick after its read, VGA_R=B6, VGA_G=49, VGA_B=FF, BLANK_N=1; during blanking RGB=0 regardless of rd_data.
6. Reset mid-frame: assert Resetn=0 for 1 cycle at v=300 -> next edge h=v=0 with reset output values; the first frame_start follows the first tick after release, and the subsequent read sequence restarts at address 0.
